// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a small byte FIFO. Frame format
//               (5..8 data bits, 1 or 2 stop bits, optional parity) is
//               latched per frame when a byte is popped. Frames are sent
//               back-to-back while the FIFO holds data.
//               Optional feature macro: UART_TX_PARITY_EN (adds the
//               parity_mode port and the PARITY state).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int COUNTER_WIDTH = 24,
    parameter int FIFO_DEPTH    = 4,
    parameter int FIFO_AW       = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               data,
    input  logic                     req,
    input  logic [COUNTER_WIDTH-1:0] cycles_per_bit,
    input  logic [1:0]               data_bits,
    input  logic                     two_stop,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]               parity_mode,
`endif
    output logic                     uart_tx_out,
    output logic                     full,
    output logic                     empty,
    output logic                     busy,
    output logic                     error,
    output logic [FIFO_AW:0]         level
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    localparam logic [FIFO_AW:0] c_depth = (FIFO_AW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0]               r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]       r_wr_ptr;
    logic [FIFO_AW-1:0]       r_rd_ptr;
    logic [FIFO_AW:0]         r_level;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_nz;
    logic [7:0]               w_head;

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    state_t                   r_state;
    state_t                   w_state_next;
    logic [COUNTER_WIDTH-1:0] r_timer;
    logic                     w_tick;
    logic [7:0]               r_shift;
    logic [7:0]               w_shift_next;
    logic [2:0]               r_bit_idx;
    logic [2:0]               w_bit_idx_next;
    logic [2:0]               w_last_idx;
    logic [1:0]               r_data_bits;
    logic                     r_two_stop;
    logic                     w_load;
    logic                     r_line;
    logic                     w_line_next;

`ifdef UART_TX_PARITY_EN
    logic [1:0]               r_parity_mode;
    logic                     r_parity_bit;
    logic                     w_parity_en;
    logic [7:0]               w_mask;
    logic                     w_parity_calc;
`endif

    // A request is accepted only when the registered full flag is clear,
    // regardless of whether a pop frees a slot on the same edge.
    assign full      = (r_level == c_depth);
    assign w_push    = req && !full;
    assign error     = req && full;
    assign w_fifo_nz = (r_level != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_pop     = w_load;

    assign level       = r_level;
    assign busy        = (r_state != IDLE);
    assign empty       = !w_fifo_nz && (r_state == IDLE);
    assign uart_tx_out = r_line;

    // FIFO data storage; no reset so it can map onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
                2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Bit period ends when the timer reaches the configured count; >= keeps
    // the timer bounded if the period is shortened while a frame runs.
    assign w_tick     = (r_timer >= cycles_per_bit);
    assign w_last_idx = {1'b0, r_data_bits} + 3'd4;

`ifdef UART_TX_PARITY_EN
    assign w_parity_en = (r_parity_mode == 2'd1) || (r_parity_mode == 2'd2);

    // Parity of the head byte restricted to the requested data length.
    always_comb begin
        w_mask = 8'hFF;
        case (data_bits)
            2'd0:    w_mask = 8'h1F;
            2'd1:    w_mask = 8'h3F;
            2'd2:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
        w_parity_calc = (^(w_head & w_mask)) ^ (parity_mode == 2'd2);
    end
`endif

    // Next-state, shift register, bit index, load strobe and next line level.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_load         = 1'b0;
        w_line_next    = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_fifo_nz) begin
                    w_load       = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_bit_idx_next = 3'd0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == w_last_idx) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = w_parity_en ? PARITY : STOP1;
`else
                        w_state_next = STOP1;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP1;
                end
            end
`endif
            STOP1: begin
                if (w_tick) begin
                    if (r_two_stop) begin
                        w_state_next = STOP2;
                    end else if (w_fifo_nz) begin
                        w_load       = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            STOP2: begin
                if (w_tick) begin
                    if (w_fifo_nz) begin
                        w_load       = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        case (w_state_next)
            START:   w_line_next = 1'b0;
            DATA:    w_line_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_line_next = r_parity_bit;
`endif
            default: w_line_next = 1'b1;
        endcase
    end

    // State register, bit timer, shift register and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_line    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_line    <= w_line_next;
            if ((r_state == IDLE) || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + COUNTER_WIDTH'(1);
            end
        end
    end

    // Frame configuration captured when a byte is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_bits   <= 2'd3;
            r_two_stop    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity_mode <= 2'd0;
            r_parity_bit  <= 1'b0;
`endif
        end else if (w_load) begin
            r_data_bits   <= data_bits;
            r_two_stop    <= two_stop;
`ifdef UART_TX_PARITY_EN
            r_parity_mode <= parity_mode;
            r_parity_bit  <= w_parity_calc;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A frame-level model
//               (byte queue + bit vector per frame) predicts every output on
//               every cycle; directed sequences pin literal waveforms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CW    = 24;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data = 8'h00;
    logic          req = 1'b0;
    logic [CW-1:0] cpb = 24'd3;
    logic [1:0]    data_bits = 2'd3;
    logic          two_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic [1:0]    parity_mode = 2'd0;
`endif
    logic          uart_tx_out;
    logic          full;
    logic          empty;
    logic          busy;
    logic          error;
    logic [AW:0]   level;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .COUNTER_WIDTH(CW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data          (data),
        .req           (req),
        .cycles_per_bit(cpb),
        .data_bits     (data_bits),
        .two_stop      (two_stop),
`ifdef UART_TX_PARITY_EN
        .parity_mode   (parity_mode),
`endif
        .uart_tx_out   (uart_tx_out),
        .full          (full),
        .empty         (empty),
        .busy          (busy),
        .error         (error),
        .level         (level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] q[$];
    bit         m_active = 0;
    bit         m_fb[0:15];
    int         m_flen = 0;
    int         m_pos = 0;
    int         m_cnt = 0;
    bit         check_on = 0;

    task automatic build_frame(input logic [7:0] b);
        int n;
        int k;
        n = int'(data_bits) + 5;
        m_fb[0] = 1'b0;
        for (int i = 0; i < n; i++) m_fb[1+i] = b[i];
        k = 1 + n;
`ifdef UART_TX_PARITY_EN
        if (parity_mode == 2'd1 || parity_mode == 2'd2) begin
            bit p;
            p = 1'b0;
            for (int i = 0; i < n; i++) p = p ^ b[i];
            if (parity_mode == 2'd2) p = ~p;
            m_fb[k] = p;
            k++;
        end
`endif
        m_fb[k] = 1'b1;
        k++;
        if (two_stop) begin
            m_fb[k] = 1'b1;
            k++;
        end
        m_flen = k;
    endtask

    task automatic model_step();
        int  pre;
        bit  do_push;
        bit  do_load;
        if (rst) begin
            q.delete();
            m_active = 0;
            m_pos = 0;
            m_cnt = 0;
        end else begin
            pre = q.size();
            do_push = req && (pre != DEPTH);
            do_load = 0;
            if (m_active) begin
                if (m_cnt >= int'(cpb)) begin
                    m_cnt = 0;
                    m_pos++;
                    if (m_pos == m_flen) begin
                        if (pre != 0) do_load = 1;
                        else m_active = 0;
                    end
                end else begin
                    m_cnt++;
                end
            end else if (pre != 0) begin
                do_load = 1;
            end
            if (do_load) begin
                build_frame(q.pop_front());
                m_active = 1;
                m_pos = 0;
                m_cnt = 0;
            end
            if (do_push) q.push_back(data);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (check_on) begin
            chk("line",  uart_tx_out, m_active ? m_fb[m_pos] : 1'b1);
            chk("level", level, q.size());
            chk("full",  full,  q.size() == DEPTH);
            chk("empty", empty, (q.size() == 0) && !m_active);
            chk("busy",  busy,  m_active);
            chk("error", error, req && (q.size() == DEPTH));
        end
    end

    // ---------------- helpers ----------------
    bit cap  [0:63];
    bit bcap [0:63];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        int t;
        t = 0;
        @(negedge clk);
        while (uart_tx_out !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("cap_start", uart_tx_out, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap[i]  = uart_tx_out;
            bcap[i] = busy;
        end
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while ((busy !== 1'b0 || level !== '0) && t < bound) begin
            step();
            t++;
        end
        chk("drain", {busy, empty}, 2'b01);
        step();
    endtask

    task automatic set_cfg(input int c, input logic [1:0] db, input logic ts, input logic [1:0] pm);
        cpb = CW'(c);
        data_bits = db;
        two_stop = ts;
`ifdef UART_TX_PARITY_EN
        parity_mode = pm;
`else
        if (pm != 2'd0) $display("note: parity request ignored in this build");
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit lit1 [0:9];
        bit lit2 [0:7];
        logic [7:0] bb;
        int bi;
        lit1 = '{0,1,0,1,0,0,1,0,1,1};
        lit2 = '{0,1,1,0,0,1,1,1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_line",  uart_tx_out, 1'b1);
        chk("rst_full",  full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_level", level, 0);
        check_on = 1;
        step();
        rst = 1'b0;
        step();

        // 8N1, cpb=3, 0xA5
        set_cfg(3, 2'd3, 1'b0, 2'd0);
        data = 8'hA5;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("a5_latency_idle", uart_tx_out, 1'b1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("a5_bit", uart_tx_out, lit1[k/4]);
        end
        @(negedge clk);
        chk("a5_busy_end",  busy, 1'b0);
        chk("a5_empty_end", empty, 1'b1);
        step();

        // 5N2, cpb=0, 0xF3
        set_cfg(0, 2'd0, 1'b1, 2'd0);
        data = 8'hF3;
        req = 1'b1;
        step();
        req = 1'b0;
        capture(9);
        for (int i = 0; i < 8; i++) chk("f3_bit", cap[i], lit2[i]);
        chk("f3_idle_busy", bcap[8], 1'b0);
        step();

        // data_bits changed mid-frame: 8 bits now, 5 bits next frame
        set_cfg(0, 2'd3, 1'b0, 2'd0);
        data = 8'hFF;
        req = 1'b1;
        step();
        step();
        req = 1'b0;
        fork
            capture(18);
            begin
                step();
                data_bits = 2'd0;
            end
        join
        chk("dbchg_stop1",  cap[9], 1'b1);
        chk("dbchg_start2", cap[10], 1'b0);
        chk("dbchg_busy16", bcap[16], 1'b1);
        chk("dbchg_busy17", bcap[17], 1'b0);
        wait_idle(100);

        // five back-to-back requests, cpb=3: fifth accepted
        set_cfg(3, 2'd3, 1'b0, 2'd0);
        for (int i = 1; i <= 5; i++) begin
            data = 8'(i);
            req = 1'b1;
            step();
        end
        req = 1'b0;
        @(negedge clk);
        chk("q5_level", level, 4);
        chk("q5_full",  full, 1'b1);
        chk("q5_noerr", error, 1'b0);
        // first sample is 3 clocks into frame 0 (start followed edge E2)
        for (int t = 0; t < 197; t++) begin
            bi = (t + 3) / 4;
            bb = 8'((bi / 10) + 1);
            if (t > 0) @(negedge clk);
            if (bi % 10 == 0)      chk("q5_start", uart_tx_out, 1'b0);
            else if (bi % 10 == 9) chk("q5_stop",  uart_tx_out, 1'b1);
            else                   chk("q5_data",  uart_tx_out, bb[bi % 10 - 1]);
        end
        step();
        wait_idle(100);

        // stalled line: sixth request rejected with an error pulse
        set_cfg(20, 2'd3, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            data = 8'h11 + 8'(i);
            req = 1'b1;
            @(negedge clk);
            chk("stall_err", error, (i == 5) ? 1'b1 : 1'b0);
            step();
        end
        req = 1'b0;
        @(negedge clk);
        chk("stall_level", level, 4);
        chk("stall_err_gone", error, 1'b0);
        step();
        wait_idle(3000);

        // reset during data bit D3 with two bytes queued
        set_cfg(3, 2'd3, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            data = 8'h3C + 8'(i);
            req = 1'b1;
            step();
        end
        req = 1'b0;
        repeat (15) step();
        chk("pre_rst_level", level, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_line",  uart_tx_out, 1'b1);
        chk("mrst_level", level, 0);
        chk("mrst_empty", empty, 1'b1);
        chk("mrst_busy",  busy, 1'b0);
        repeat (60) @(negedge clk);
        chk("mrst_quiet", busy, 1'b0);
        step();

`ifdef UART_TX_PARITY_EN
        for (int pm = 1; pm <= 2; pm++) begin
            set_cfg(0, 2'd3, 1'b0, 2'(pm));
            data = 8'h07;
            req = 1'b1;
            step();
            req = 1'b0;
            capture(12);
            chk("par_d7",    cap[8], 1'b0);
            chk("par_bit",   cap[9], (pm == 1) ? 1'b1 : 1'b0);
            chk("par_stop",  cap[10], 1'b1);
            chk("par_busy10", bcap[10], 1'b1);
            chk("par_busy11", bcap[11], 1'b0);
            step();
        end
`endif

        // randomized traffic against the model
        for (int seg = 0; seg < 6; seg++) begin
            wait_idle(5000);
            cpb = CW'($urandom_range(0, 3));
            for (int c = 0; c < 500; c++) begin
                req  = ($urandom_range(0, 2) == 0);
                data = 8'($urandom);
                if ($urandom_range(0, 19) == 0) data_bits = 2'($urandom);
                if ($urandom_range(0, 19) == 0) two_stop = 1'($urandom);
`ifdef UART_TX_PARITY_EN
                if ($urandom_range(0, 19) == 0) parity_mode = 2'($urandom);
`endif
                rst = ($urandom_range(0, 399) == 0);
                step();
            end
            req = 1'b0;
            rst = 1'b0;
        end
        wait_idle(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
